// File: rtl/lab5_mcore_mem_responder_pkg.sv
// rtl/lab5_mcore_mem_responder_pkg.sv - 16B memory message types and constants for the responder
package lab5_mcore_mem_responder_pkg;

    localparam logic [3:0] MEM_MSG_TYPE_READ  = 4'd0;
    localparam logic [3:0] MEM_MSG_TYPE_WRITE = 4'd1;
    localparam logic [3:0] MEM_MSG_TYPE_INIT  = 4'd2;
    localparam int         NBYTES_FULL        = 16;

    typedef struct packed {
        logic [3:0]   typ;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [3:0]   typ;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    // A zero length field encodes a full 16-byte access.
    function automatic logic [4:0] len_to_nbytes(input logic [3:0] len);
        return (len == 4'd0) ? 5'(NBYTES_FULL) : {1'b0, len};
    endfunction

endpackage

// File: rtl/lab5_mcore_mem_resp_queue.sv
// rtl/lab5_mcore_mem_resp_queue.sv - circular response FIFO; enqueue and dequeue may coincide when full
module lab5_mcore_mem_resp_queue
    import lab5_mcore_mem_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enq_val,
    input  mem_resp_16B_t enq_msg,
    output logic          deq_val,
    input  logic          deq_rdy,
    output mem_resp_16B_t deq_msg
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    mem_resp_16B_t entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          deq;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign deq     = deq_val && deq_rdy;
    assign deq_val = (count != '0);
    assign deq_msg = entries[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_val) tail <= next_ptr(tail);
            if (deq)     head <= next_ptr(head);
            count <= count + CW'(enq_val) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_val) entries[tail] <= enq_msg;
    end

endmodule

// File: rtl/lab5_mcore_mem_responder.sv
// rtl/lab5_mcore_mem_responder.sv - two-port round-robin 16B memory responder with credit-checked queues
module lab5_mcore_mem_responder
    import lab5_mcore_mem_responder_pkg::*;
#(
    parameter int NUM_LINES  = 1024,
    parameter int LATENCY    = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  mem_req_16B_t  imemreq_msg,
    input  logic          imemreq_val,
    output logic          imemreq_rdy,
    output mem_resp_16B_t imemresp_msg,
    output logic          imemresp_val,
    input  logic          imemresp_rdy,
    input  mem_req_16B_t  dmemreq_msg,
    input  logic          dmemreq_val,
    output logic          dmemreq_rdy,
    output mem_resp_16B_t dmemresp_msg,
    output logic          dmemresp_val,
    input  logic          dmemresp_rdy,
    output logic          err
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int CW    = $clog2(RESP_DEPTH + 1);

    logic [1:0]    req_val, req_rdy, eligible, contend, acc, resp_val, resp_rdy, deq, enq;
    logic [CW-1:0] outstanding [2];
    logic          last_grant;
    logic          acc_any;
    logic          sel_port;
    mem_req_16B_t  sel_req;

    logic [127:0]     sram [NUM_LINES];
    logic [IDX_W-1:0] line;
    logic [3:0]       off;
    logic [4:0]       nbytes;
    logic [127:0]     line_data, rd_data, wr_line;
    logic             is_rd, is_wr, bad_type, crosses;
    mem_resp_16B_t    acc_msg;
    logic             unused_addr_bits;

    logic             pipe_val  [LATENCY];
    logic             pipe_port [LATENCY];
    mem_resp_16B_t    pipe_msg  [LATENCY];

    assign req_val  = {dmemreq_val, imemreq_val};
    assign resp_rdy = {dmemresp_rdy, imemresp_rdy};

    // last_grant = 1 means dmem won most recently, so imem is favoured next.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            eligible[p] = outstanding[p] < CW'(RESP_DEPTH);
            contend[p]  = req_val[p] && eligible[p];
        end
        req_rdy[0] = !reset && eligible[0] && (!contend[1] || last_grant);
        req_rdy[1] = !reset && eligible[1] && (!contend[0] || !last_grant);
    end

    assign acc      = req_val & req_rdy;
    assign acc_any  = |acc;
    assign sel_port = acc[1];
    assign sel_req  = acc[1] ? dmemreq_msg : imemreq_msg;

    assign line             = sel_req.addr[4+IDX_W-1:4];
    assign off              = sel_req.addr[3:0];
    assign nbytes           = len_to_nbytes(sel_req.len);
    assign line_data        = sram[line];
    assign unused_addr_bits = ^sel_req.addr[31:4+IDX_W];

    assign is_rd    = (sel_req.typ == MEM_MSG_TYPE_READ);
    assign is_wr    = (sel_req.typ == MEM_MSG_TYPE_WRITE) || (sel_req.typ == MEM_MSG_TYPE_INIT);
    assign bad_type = !(is_rd || is_wr);
    assign crosses  = ({1'b0, off} + nbytes) > 5'(NBYTES_FULL);

    // Bytes that would fall past the end of the line are simply not selected.
    always_comb begin
        rd_data = '0;
        wr_line = line_data;
        for (int i = 0; i < NBYTES_FULL; i++) begin
            if (i < int'(nbytes) && int'(off) + i < NBYTES_FULL)
                rd_data[i*8 +: 8] = line_data[(int'(off) + i)*8 +: 8];
            if (i >= int'(off) && i - int'(off) < int'(nbytes))
                wr_line[i*8 +: 8] = sel_req.data[(i - int'(off))*8 +: 8];
        end
    end

    always_comb begin
        acc_msg        = '0;
        acc_msg.typ    = sel_req.typ;
        acc_msg.opaque = sel_req.opaque;
        acc_msg.test   = 2'b00;
        acc_msg.len    = sel_req.len;
        acc_msg.data   = is_rd ? rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (acc_any && is_wr) sram[line] <= wr_line;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err        <= 1'b0;
            last_grant <= 1'b1;
        end else if (acc_any) begin
            last_grant <= sel_port;
            if (bad_type || crosses) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) pipe_val[i] <= 1'b0;
        end else begin
            pipe_val[0] <= acc_any;
            for (int i = 1; i < LATENCY; i++) pipe_val[i] <= pipe_val[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_port[0] <= sel_port;
        pipe_msg[0]  <= acc_msg;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_port[i] <= pipe_port[i-1];
            pipe_msg[i]  <= pipe_msg[i-1];
        end
    end

    assign enq[0] = pipe_val[LATENCY-1] && !pipe_port[LATENCY-1];
    assign enq[1] = pipe_val[LATENCY-1] &&  pipe_port[LATENCY-1];
    assign deq    = resp_val & resp_rdy;

    // A credit returns only at the dequeue edge, so the queue can never overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) outstanding[p] <= '0;
        end else begin
            for (int p = 0; p < 2; p++)
                outstanding[p] <= outstanding[p] + CW'(acc[p]) - CW'(deq[p]);
        end
    end

    lab5_mcore_mem_resp_queue #(.DEPTH(RESP_DEPTH)) u_iq (
        .clk     (clk),
        .reset   (reset),
        .enq_val (enq[0]),
        .enq_msg (pipe_msg[LATENCY-1]),
        .deq_val (resp_val[0]),
        .deq_rdy (resp_rdy[0]),
        .deq_msg (imemresp_msg)
    );

    lab5_mcore_mem_resp_queue #(.DEPTH(RESP_DEPTH)) u_dq (
        .clk     (clk),
        .reset   (reset),
        .enq_val (enq[1]),
        .enq_msg (pipe_msg[LATENCY-1]),
        .deq_val (resp_val[1]),
        .deq_rdy (resp_rdy[1]),
        .deq_msg (dmemresp_msg)
    );

    assign imemreq_rdy  = req_rdy[0];
    assign dmemreq_rdy  = req_rdy[1];
    assign imemresp_val = resp_val[0];
    assign dmemresp_val = resp_val[1];

endmodule

// File: tb/tb_lab5_mcore_mem_responder.sv
// tb/tb_lab5_mcore_mem_responder.sv - scoreboard bench for the two-port memory responder
module tb_lab5_mcore_mem_responder;
    import lab5_mcore_mem_responder_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    mem_req_16B_t  imemreq_msg, dmemreq_msg;
    logic          imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
    mem_resp_16B_t imemresp_msg, dmemresp_msg;
    logic          imemresp_val, imemresp_rdy, dmemresp_val, dmemresp_rdy;
    logic          err;

    lab5_mcore_mem_responder #(.NUM_LINES(1024), .LATENCY(LAT), .RESP_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .imemreq_msg  (imemreq_msg),
        .imemreq_val  (imemreq_val),
        .imemreq_rdy  (imemreq_rdy),
        .imemresp_msg (imemresp_msg),
        .imemresp_val (imemresp_val),
        .imemresp_rdy (imemresp_rdy),
        .dmemreq_msg  (dmemreq_msg),
        .dmemreq_val  (dmemreq_val),
        .dmemreq_rdy  (dmemreq_rdy),
        .dmemresp_msg (dmemresp_msg),
        .dmemresp_val (dmemresp_val),
        .dmemresp_rdy (dmemresp_rdy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]    mdl [1024*16];
    mem_resp_16B_t q0[$], q1[$];
    int            c0[$], c1[$];
    bit            exp_err = 0;
    bit            chk_lat = 0;
    bit            rnd_bp  = 0;
    logic [127:0]  last_data [2];
    int            n_acc, first_acc, last_acc, prev_port, prev_cyc, alt_bad;

    task automatic check(input string name, input logic [145:0] act, input logic [145:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic mem_req_16B_t mk(input logic [3:0] t, input int op, input logic [31:0] a,
                                        input logic [3:0] l, input logic [127:0] d);
        mem_req_16B_t r;
        r.typ = t; r.opaque = 8'(op); r.addr = a; r.len = l; r.data = d;
        return r;
    endfunction

    // Byte-granular reference memory; the expected response is fixed at accept time.
    task automatic model_apply(input int p, input mem_req_16B_t m);
        mem_resp_16B_t r;
        int off, nb, base;
        off  = int'(m.addr[3:0]);
        nb   = (m.len == 4'd0) ? 16 : int'(m.len);
        base = int'(m.addr[13:4]) * 16;
        r.typ = m.typ; r.opaque = m.opaque; r.test = 2'b00; r.len = m.len; r.data = '0;
        if (off + nb > 16 || m.typ > 4'd2) exp_err = 1;
        for (int i = 0; i < nb && off + i < 16; i++) begin
            if (m.typ == 4'd0) r.data[i*8 +: 8] = mdl[base+off+i];
            else if (m.typ == 4'd1 || m.typ == 4'd2) mdl[base+off+i] = m.data[i*8 +: 8];
        end
        if (p == 0) begin q0.push_back(r); c0.push_back(cyc); end
        else        begin q1.push_back(r); c1.push_back(cyc); end
        if (n_acc == 0) first_acc = cyc;
        if (n_acc > 0 && cyc == prev_cyc + 1 && p == prev_port) alt_bad++;
        n_acc++; last_acc = cyc; prev_port = p; prev_cyc = cyc;
    endtask

    task automatic send(input int p, input mem_req_16B_t m);
        bit a = 0;
        @(negedge clk);
        if (p == 0) begin imemreq_msg = m; imemreq_val = 1; end
        else        begin dmemreq_msg = m; dmemreq_val = 1; end
        for (int k = 0; k < 1000; k++) begin
            #2 a = (p == 0) ? imemreq_rdy : dmemreq_rdy;
            @(posedge clk); #1;
            if (a) break;
            @(negedge clk);
        end
        if (p == 0) imemreq_val = 0; else dmemreq_val = 0;
        checks++;
        if (!a) begin
            errors++;
            $display("FAIL accept_timeout port %0d: got no accept, expected accept within 1000 cycles", p);
        end else model_apply(p, m);
    endtask

    task automatic pop_check(input int p, input mem_resp_16B_t act);
        mem_resp_16B_t e;
        int c;
        checks++;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_resp port %0d: got %h expected no response", p, act);
            return;
        end
        checks--;
        if (p == 0) begin e = q0.pop_front(); c = c0.pop_front(); end
        else        begin e = q1.pop_front(); c = c1.pop_front(); end
        check((p == 0) ? "imemresp_msg" : "dmemresp_msg", act, e);
        if (chk_lat) check("resp_latency", 146'(cyc - c), 146'(LAT));
        last_data[p] = act.data;
    endtask

    always begin
        @(negedge clk);
        #3;
        if (imemresp_val && imemresp_rdy) pop_check(0, imemresp_msg);
        if (dmemresp_val && dmemresp_rdy) pop_check(1, dmemresp_msg);
    end

    always @(negedge clk) begin
        if (rnd_bp) begin
            imemresp_rdy = 1'($urandom_range(0, 1));
            dmemresp_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_drain();
        for (int k = 0; k < 2000; k++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        check("drain_pending", 146'(q0.size() + q1.size()), 146'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic rnd_stream(input int p, input int n);
        mem_req_16B_t r;
        int off, nb;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            off = $urandom_range(0, 15);
            nb  = $urandom_range(1, 16 - off);
            r = mk(4'($urandom_range(0, 2)), i,
                   ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 7) << 4) | 32'(off),
                   4'(nb), {$urandom, $urandom, $urandom, $urandom});
            send(p, r);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit a;
        reset = 1; imemreq_val = 0; dmemreq_val = 0; imemreq_msg = '0; dmemreq_msg = '0;
        imemresp_rdy = 0; dmemresp_rdy = 0; n_acc = 0; alt_bad = 0;
        #1;
        check("rst_imemreq_rdy",  146'(imemreq_rdy),  146'(0));
        check("rst_dmemreq_rdy",  146'(dmemreq_rdy),  146'(0));
        check("rst_imemresp_val", 146'(imemresp_val), 146'(0));
        check("rst_dmemresp_val", 146'(dmemresp_val), 146'(0));
        check("rst_err",          146'(err),          146'(0));
        repeat (3) @(negedge clk);
        reset = 0; imemresp_rdy = 1; dmemresp_rdy = 1;

        for (int l = 0; l < 8; l++)
            send(1, mk(MEM_MSG_TYPE_INIT, l, 32'(l*16), 4'd0, {$urandom, $urandom, $urandom, $urandom}));
        send(1, mk(MEM_MSG_TYPE_INIT, 9, 32'h2000, 4'd0, 128'hFFEEDDCC_BBAA9988_77665544_33221100));
        wait_drain();

        // Full-line write then read, with exact latency on an empty queue.
        send(1, mk(MEM_MSG_TYPE_WRITE, 1, 32'h1000, 4'd0, 128'h0F0E0D0C_0B0A0908_07060504_03020100));
        wait_drain();
        chk_lat = 1;
        send(0, mk(MEM_MSG_TYPE_READ, 8'hA5, 32'h1000, 4'd0, '0));
        wait_drain();
        chk_lat = 0;
        check("t1_read_data", 146'(last_data[0]), 146'(128'h0F0E0D0C_0B0A0908_07060504_03020100));

        // Both ports streaming: strict alternation, one accept per cycle.
        n_acc = 0; alt_bad = 0;
        fork
            for (int i = 0; i < 20; i++) send(0, mk(MEM_MSG_TYPE_READ, i, 32'((i % 8) * 16), 4'd0, '0));
            for (int i = 0; i < 20; i++) send(1, mk(MEM_MSG_TYPE_WRITE, i, 32'((i % 8) * 16 + 4), 4'd8,
                                                    {$urandom, $urandom, $urandom, $urandom}));
        join
        check("t2_accepts",  146'(n_acc), 146'(40));
        check("t2_span",     146'(last_acc - first_acc), 146'(39));
        check("t2_alternate", 146'(alt_bad), 146'(0));
        wait_drain();
        check("t2_err", 146'(err), 146'(0));

        // Credit limit on a stalled dmem response queue; imem unaffected.
        dmemresp_rdy = 0; n = 0;
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    dmemreq_msg = mk(MEM_MSG_TYPE_READ, n, 32'((n % 8) * 16), 4'd0, '0);
                    dmemreq_val = 1;
                    #2 a = dmemreq_rdy;
                    @(posedge clk); #1;
                    if (a) begin model_apply(1, dmemreq_msg); n++; end
                end
                dmemreq_val = 0;
            end
            begin
                repeat (6) @(negedge clk);
                send(0, mk(MEM_MSG_TYPE_READ, 50, 32'h0030, 4'd0, '0));
                send(0, mk(MEM_MSG_TYPE_READ, 51, 32'h0040, 4'd4, '0));
            end
        join
        check("t3_accepted", 146'(n), 146'(DEPTH));
        check("t3_rdy_low", 146'(dmemreq_rdy), 146'(0));
        repeat (5) @(negedge clk);
        check("t3_imem_served", 146'(q0.size()), 146'(0));
        dmemresp_rdy = 1;
        #2 check("t3_rdy_still_low", 146'(dmemreq_rdy), 146'(0));
        @(posedge clk); #1;
        check("t3_rdy_back", 146'(dmemreq_rdy), 146'(1));
        wait_drain();

        // Partial write, full read, line-crossing read.
        send(0, mk(MEM_MSG_TYPE_WRITE, 60, 32'h2004, 4'd4, 128'hDEADBEEF));
        send(0, mk(MEM_MSG_TYPE_READ, 61, 32'h2000, 4'd0, '0));
        wait_drain();
        check("t4_word", 146'(last_data[0][63:32]), 146'(32'hDEADBEEF));
        check("t4_other", 146'({last_data[0][127:64], last_data[0][31:0]}), 146'(96'hFFEEDDCC_BBAA9988_33221100));
        check("t4_err_clear", 146'(err), 146'(0));
        send(0, mk(MEM_MSG_TYPE_READ, 62, 32'h200E, 4'd4, '0));
        wait_drain();
        check("t4_cross_data", 146'(last_data[0]), 146'(128'hFFEE));
        check("t4_err_set", 146'(err), 146'(1));

        // Illegal type, then reset with requests in flight.
        @(negedge clk) reset = 1;
        @(negedge clk) reset = 0;
        exp_err = 0;
        check("t5_err_after_rst", 146'(err), 146'(0));
        send(0, mk(4'd7, 70, 32'h0010, 4'd0, 128'h1234));
        wait_drain();
        check("t5_err_type", 146'(err), 146'(1));
        imemresp_rdy = 0; dmemresp_rdy = 0;
        send(0, mk(MEM_MSG_TYPE_READ, 71, 32'h0000, 4'd0, '0));
        send(1, mk(MEM_MSG_TYPE_READ, 72, 32'h0010, 4'd0, '0));
        send(0, mk(MEM_MSG_TYPE_READ, 73, 32'h0020, 4'd0, '0));
        @(negedge clk) reset = 1;
        #1;
        check("t5_imemreq_rdy",  146'(imemreq_rdy),  146'(0));
        check("t5_dmemreq_rdy",  146'(dmemreq_rdy),  146'(0));
        check("t5_imemresp_val", 146'(imemresp_val), 146'(0));
        check("t5_dmemresp_val", 146'(dmemresp_val), 146'(0));
        check("t5_err_rst",      146'(err),          146'(0));
        q0.delete(); q1.delete(); c0.delete(); c1.delete(); exp_err = 0;
        repeat (2) @(negedge clk);
        reset = 0; imemresp_rdy = 1; dmemresp_rdy = 1;
        repeat (12) @(negedge clk);

        // Random traffic with random response backpressure.
        rnd_bp = 1;
        fork
            rnd_stream(0, 2500);
            rnd_stream(1, 2500);
        join
        rnd_bp = 0;
        #1 imemresp_rdy = 1; dmemresp_rdy = 1;
        wait_drain();
        check("t6_err", 146'(err), 146'(exp_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
